irq_link_stack: RTL and testbench

Parametrised link/status stack for nested fast interrupts and call-link instructions, sitting beside the CPU control unit. It holds return addresses and saved status words as tagged frames. It tracks stack level and interrupt nesting depth, and returns popped frames one cycle after the request. An optional checker rejects overflow, underflow and frame-type mismatches.

---
 rtl/irq_stack_pkg.sv | 27 ++
 rtl/irq_stack_ram.sv | 41 ++++
 rtl/irq_link_stack.sv | 194 +++++++++++++++++++
 tb/tb_irq_link_stack.sv | 306 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/irq_stack_pkg.sv
// irq_stack_pkg: shared op codes, frame tags and storage sizing for the
// interrupt/call link stack.
// Build option: IRQ_STACK_CHECK_EN stores a 2-bit tag beside every stack
// word and enables the overflow/underflow/mismatch checker.
package irq_stack_pkg;

    typedef enum logic [1:0] {
        OP_PUSH_CALL = 2'b00,
        OP_PUSH_IRQ  = 2'b01,
        OP_POP_CALL  = 2'b10,
        OP_POP_IRQ   = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        TAG_NONE = 2'b00,
        TAG_CALL = 2'b01,
        TAG_LINK = 2'b10,
        TAG_STAT = 2'b11
    } tag_e;

`ifdef IRQ_STACK_CHECK_EN
    localparam int TAG_STORE_W = 2;
`else
    localparam int TAG_STORE_W = 0;
`endif

endpackage

// File: rtl/irq_stack_ram.sv
// irq_stack_ram: DEPTH x W register array for the link stack.
// Ports:
//   clk              write clock
//   we_a / wdata_a   write port A, address addr_a
//   we_b / wdata_b   write port B, address addr_a+1 (wraps)
//   raddr_0/rdata_0  asynchronous read port 0
//   raddr_1/rdata_1  asynchronous read port 1
// Build option: none (width is chosen by the instantiating module).
module irq_stack_ram #(
    parameter int  DEPTH = 32,
    parameter int  W     = 34,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we_a,
    input  logic          we_b,
    input  logic [AW-1:0] addr_a,
    input  logic [W-1:0]  wdata_a,
    input  logic [W-1:0]  wdata_b,
    input  logic [AW-1:0] raddr_0,
    input  logic [AW-1:0] raddr_1,
    output logic [W-1:0]  rdata_0,
    output logic [W-1:0]  rdata_1
);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] addr_b;

    assign addr_b = addr_a + AW'(1);

    // NOTE: the array has no reset; contents are only meaningful below the
    // stack level, so resetting it would only cost area and reset fan-out.
    always_ff @(posedge clk) begin
        if (we_a) mem[addr_a] <= wdata_a;
        if (we_b) mem[addr_b] <= wdata_b;
    end

    assign rdata_0 = mem[raddr_0];
    assign rdata_1 = mem[raddr_1];

endmodule

// File: rtl/irq_link_stack.sv
// irq_link_stack: link/status stack for nested fast interrupts and call-link
// instructions. Pops respond one cycle after acceptance via registered rsp_*.
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   op_valid, op            operation request and code (irq_stack_pkg::op_e)
//   link_in, status_in      words to push
//   rsp_valid/link/status   one-cycle pop result (or rejection) pulse
//   rsp_err                 rejection marker alongside rsp_valid
//   level, irq_depth        words stacked, outstanding interrupt frames
//   empty, full             level==0 / level==DEPTH
//   err_clr                 clears sticky flags
//   err_overflow/underflow/mismatch  sticky checker flags
// Build option: IRQ_STACK_CHECK_EN enables tags, rejection and sticky flags;
// without it level wraps modulo DEPTH and all error outputs are 0.
module irq_link_stack
    import irq_stack_pkg::*;
#(
    parameter int  DATA_W = 32,
    parameter int  DEPTH  = 32,
    localparam int PTR_W  = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    input  logic [1:0]        op,
    input  logic [DATA_W-1:0] link_in,
    input  logic [DATA_W-1:0] status_in,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_link,
    output logic [DATA_W-1:0] rsp_status,
    output logic              rsp_err,
    output logic [PTR_W:0]    level,
    output logic [PTR_W-1:0]  irq_depth,
    output logic              empty,
    output logic              full,
    input  logic              err_clr,
    output logic              err_overflow,
    output logic              err_underflow,
    output logic              err_mismatch
);

    localparam int LVL_W  = PTR_W + 1;
    localparam int WORD_W = DATA_W + TAG_STORE_W;

    op_e               op_c;
    logic [PTR_W-1:0]  ptr, top_addr, sec_addr;
    logic [WORD_W-1:0] wdata_a, wdata_b, rdata_top, rdata_sec;
    logic [DATA_W-1:0] top_data, sec_data, pop_link, pop_status;
    logic              reject, accept, is_pop, we_a, we_b;
    logic [LVL_W-1:0]  level_nxt;
    logic [PTR_W-1:0]  depth_nxt;

    assign op_c     = op_e'(op);
    assign is_pop   = op[1];
    assign ptr      = level[PTR_W-1:0];
    // Top of stack and the word beneath it; reads wrap like the pointer.
    assign top_addr = ptr - PTR_W'(1);
    assign sec_addr = ptr - PTR_W'(2);
    assign top_data = rdata_top[DATA_W-1:0];
    assign sec_data = rdata_sec[DATA_W-1:0];

    assign accept = op_valid && !reject;
    assign we_a   = accept && !is_pop;
    assign we_b   = accept && (op_c == OP_PUSH_IRQ);

    irq_stack_ram #(.DEPTH(DEPTH), .W(WORD_W)) u_ram (
        .clk     (clk),
        .we_a    (we_a),
        .we_b    (we_b),
        .addr_a  (ptr),
        .wdata_a (wdata_a),
        .wdata_b (wdata_b),
        .raddr_0 (top_addr),
        .raddr_1 (sec_addr),
        .rdata_0 (rdata_top),
        .rdata_1 (rdata_sec)
    );

`ifdef IRQ_STACK_CHECK_EN
    localparam logic [LVL_W-1:0] DEPTH_L = LVL_W'(DEPTH);

    tag_e top_tag;
    logic rej_ovf, rej_unf, rej_mis;
    logic unused_sec_tag;

    assign wdata_a = {(op_c == OP_PUSH_IRQ) ? TAG_LINK : TAG_CALL, link_in};
    assign wdata_b = {TAG_STAT, status_in};
    assign top_tag = tag_e'(rdata_top[WORD_W-1 -: 2]);
    assign unused_sec_tag = ^rdata_sec[WORD_W-1 -: 2];

    always_comb begin
        // NOTE: defaults first so no path leaves a signal unassigned, which
        // would otherwise infer a latch.
        rej_ovf = 1'b0;
        rej_unf = 1'b0;
        rej_mis = 1'b0;
        if (op_valid) begin
            unique case (op_c)
                OP_PUSH_CALL: rej_ovf = (level == DEPTH_L);
                OP_PUSH_IRQ:  rej_ovf = (level > DEPTH_L - LVL_W'(2));
                OP_POP_CALL: begin
                    rej_unf = (level == '0);
                    rej_mis = !rej_unf && (top_tag != TAG_CALL);
                end
                OP_POP_IRQ: begin
                    rej_unf = (level < LVL_W'(2));
                    rej_mis = !rej_unf && (top_tag != TAG_STAT);
                end
            endcase
        end
    end

    assign reject = rej_ovf || rej_unf || rej_mis;
    assign full   = (level == DEPTH_L);

    // A new error in the same cycle as err_clr keeps its flag set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_err       <= 1'b0;
            err_overflow  <= 1'b0;
            err_underflow <= 1'b0;
            err_mismatch  <= 1'b0;
        end else begin
            rsp_err       <= reject;
            err_overflow  <= (err_overflow  && !err_clr) || rej_ovf;
            err_underflow <= (err_underflow && !err_clr) || rej_unf;
            err_mismatch  <= (err_mismatch  && !err_clr) || rej_mis;
        end
    end
`else
    logic unused_err_clr;

    assign unused_err_clr = err_clr;
    assign wdata_a        = link_in;
    assign wdata_b        = status_in;
    assign reject         = 1'b0;
    assign full           = 1'b0;
    assign rsp_err        = 1'b0;
    assign err_overflow   = 1'b0;
    assign err_underflow  = 1'b0;
    assign err_mismatch   = 1'b0;
`endif

    assign empty = (level == '0);

    always_comb begin
        level_nxt  = level;
        depth_nxt  = irq_depth;
        pop_link   = '0;
        pop_status = '0;
        if (accept) begin
            unique case (op_c)
                OP_PUSH_CALL: level_nxt = level + LVL_W'(1);
                OP_PUSH_IRQ: begin
                    level_nxt = level + LVL_W'(2);
                    depth_nxt = irq_depth + PTR_W'(1);
                end
                OP_POP_CALL: begin
                    level_nxt = level - LVL_W'(1);
                    pop_link  = top_data;
                end
                OP_POP_IRQ: begin
                    level_nxt  = level - LVL_W'(2);
                    depth_nxt  = irq_depth - PTR_W'(1);
                    pop_link   = sec_data;
                    pop_status = top_data;
                end
            endcase
        end
`ifndef IRQ_STACK_CHECK_EN
        // Legacy mode: level wraps modulo DEPTH, so its MSB never sets.
        level_nxt[PTR_W] = 1'b0;
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level      <= '0;
            irq_depth  <= '0;
            rsp_valid  <= 1'b0;
            rsp_link   <= '0;
            rsp_status <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values, independent of statement order.
            level      <= level_nxt;
            irq_depth  <= depth_nxt;
            rsp_valid  <= (accept && is_pop) || reject;
            rsp_link   <= pop_link;
            rsp_status <= pop_status;
        end
    end

endmodule

// File: tb/tb_irq_link_stack.sv
// tb_irq_link_stack: directed self-checking bench for irq_link_stack with a
// reference model and a response scoreboard queue. Covers both builds
// (IRQ_STACK_CHECK_EN defined or not).
module tb_irq_link_stack;
    import irq_stack_pkg::*;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 32;
    localparam int PTR_W  = 5;
`ifdef IRQ_STACK_CHECK_EN
    localparam bit CHK = 1'b1;
`else
    localparam bit CHK = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              op_valid = 1'b0;
    logic [1:0]        op = 2'b00;
    logic [DATA_W-1:0] link_in = '0;
    logic [DATA_W-1:0] status_in = '0;
    logic              err_clr = 1'b0;
    logic              rsp_valid, rsp_err, empty, full;
    logic [DATA_W-1:0] rsp_link, rsp_status;
    logic [PTR_W:0]    level;
    logic [PTR_W-1:0]  irq_depth;
    logic              err_overflow, err_underflow, err_mismatch;

    irq_link_stack #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .op_valid      (op_valid),
        .op            (op),
        .link_in       (link_in),
        .status_in     (status_in),
        .rsp_valid     (rsp_valid),
        .rsp_link      (rsp_link),
        .rsp_status    (rsp_status),
        .rsp_err       (rsp_err),
        .level         (level),
        .irq_depth     (irq_depth),
        .empty         (empty),
        .full          (full),
        .err_clr       (err_clr),
        .err_overflow  (err_overflow),
        .err_underflow (err_underflow),
        .err_mismatch  (err_mismatch)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] link;
        logic [31:0] status;
        logic        err;
    } rsp_t;

    rsp_t        exp_q[$];
    logic [31:0] m_data [DEPTH];
    bit   [1:0]  m_tag  [DEPTH];
    int          m_level, m_depth;
    bit          m_ovf, m_unf, m_mis;
    int          n_cmp, n_mis;
    logic [31:0] last_link, last_status;
    logic        last_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_level = 0;
        m_depth = 0;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        m_mis = 1'b0;
    endtask

    task automatic check_reset_values();
        check("rst_rsp_valid", {63'd0, rsp_valid}, 64'd0);
        check("rst_rsp_link", {32'd0, rsp_link}, 64'd0);
        check("rst_rsp_status", {32'd0, rsp_status}, 64'd0);
        check("rst_rsp_err", {63'd0, rsp_err}, 64'd0);
        check("rst_level", {58'd0, level}, 64'd0);
        check("rst_irq_depth", {59'd0, irq_depth}, 64'd0);
        check("rst_empty", {63'd0, empty}, 64'd1);
        check("rst_full", {63'd0, full}, 64'd0);
        check("rst_flags", {61'd0, err_overflow, err_underflow, err_mismatch}, 64'd0);
    endtask

    // Compares everything observable against the model, draining the
    // scoreboard when a response appears.
    task automatic check_outputs();
        rsp_t e;
        if (rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("unexpected_rsp_valid", {63'd0, rsp_valid}, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("rsp_link", {32'd0, rsp_link}, {32'd0, e.link});
                check("rsp_status", {32'd0, rsp_status}, {32'd0, e.status});
                check("rsp_err", {63'd0, rsp_err}, {63'd0, e.err});
                last_link   = rsp_link;
                last_status = rsp_status;
                last_err    = rsp_err;
            end
        end else if (exp_q.size() != 0) begin
            check("missing_rsp_valid", {63'd0, rsp_valid}, 64'd1);
            exp_q.delete(0);
        end
        check("level", {58'd0, level}, 64'(m_level));
        check("irq_depth", {59'd0, irq_depth}, 64'(m_depth));
        check("empty", {63'd0, empty}, {63'd0, m_level == 0});
        check("full", {63'd0, full}, {63'd0, CHK && m_level == DEPTH});
        check("err_flags", {61'd0, err_overflow, err_underflow, err_mismatch},
              {61'd0, m_ovf, m_unf, m_mis});
    endtask

    // One clock cycle: update the model, drive the request, check after the edge.
    task automatic do_op(input bit v, input logic [1:0] o, input logic [31:0] l,
                         input logic [31:0] s, input bit clr);
        bit   ovf, unf, mis;
        rsp_t e;
        int   top, sec;
        ovf = 1'b0; unf = 1'b0; mis = 1'b0;
        top = (m_level + DEPTH - 1) % DEPTH;
        sec = (m_level + DEPTH - 2) % DEPTH;
        if (v) begin
            if (CHK) begin
                case (o)
                    OP_PUSH_CALL: ovf = (m_level > DEPTH - 1);
                    OP_PUSH_IRQ:  ovf = (m_level > DEPTH - 2);
                    OP_POP_CALL: begin
                        unf = (m_level < 1);
                        if (!unf) mis = (m_tag[top] != 2'b01);
                    end
                    default: begin
                        unf = (m_level < 2);
                        if (!unf) mis = (m_tag[top] != 2'b11);
                    end
                endcase
            end
            if (ovf || unf || mis) begin
                e = '{link: 32'd0, status: 32'd0, err: 1'b1};
                exp_q.push_back(e);
            end else begin
                case (o)
                    OP_PUSH_CALL: begin
                        m_data[m_level % DEPTH] = l;
                        m_tag[m_level % DEPTH]  = 2'b01;
                        m_level = m_level + 1;
                    end
                    OP_PUSH_IRQ: begin
                        m_data[m_level % DEPTH]       = l;
                        m_tag[m_level % DEPTH]        = 2'b10;
                        m_data[(m_level + 1) % DEPTH] = s;
                        m_tag[(m_level + 1) % DEPTH]  = 2'b11;
                        m_level = m_level + 2;
                        m_depth = m_depth + 1;
                    end
                    OP_POP_CALL: begin
                        e = '{link: m_data[top], status: 32'd0, err: 1'b0};
                        exp_q.push_back(e);
                        m_level = m_level - 1;
                    end
                    default: begin
                        e = '{link: m_data[sec], status: m_data[top], err: 1'b0};
                        exp_q.push_back(e);
                        m_level = m_level - 2;
                        m_depth = m_depth - 1;
                    end
                endcase
                if (!CHK) begin
                    m_level = (m_level + DEPTH) % DEPTH;
                    m_depth = (m_depth + 32) % 32;
                end
            end
        end
        if (CHK) begin
            m_ovf = (m_ovf && !clr) || ovf;
            m_unf = (m_unf && !clr) || unf;
            m_mis = (m_mis && !clr) || mis;
        end
        op_valid  = v;
        op        = o;
        link_in   = l;
        status_in = s;
        err_clr   = clr;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        err_clr  = 1'b0;
        check_outputs();
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        last_link = '0; last_status = '0; last_err = 1'b0;
        model_reset();

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        check_reset_values();
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check_outputs();

        // Single interrupt frame round trip.
        do_op(1, OP_PUSH_IRQ, 32'h100, 32'hF000_0010, 0);
        check("t1_depth_after_push", {59'd0, irq_depth}, 64'd1);
        do_op(1, OP_POP_IRQ, 0, 0, 0);
        check("t1_link", {32'd0, last_link}, 64'h100);
        check("t1_status", {32'd0, last_status}, 64'hF000_0010);
        check("t1_level", {58'd0, level}, 64'd0);

        // Nesting: responses (0x300,0xB), (0x200,0), (0x100,0xA).
        do_op(1, OP_PUSH_IRQ, 32'h100, 32'hA, 0);
        do_op(1, OP_PUSH_CALL, 32'h200, 0, 0);
        do_op(1, OP_PUSH_IRQ, 32'h300, 32'hB, 0);
        check("t2_depth2", {59'd0, irq_depth}, 64'd2);
        do_op(1, OP_POP_IRQ, 0, 0, 0);
        check("t2_pop1", {last_link, last_status}, {32'h300, 32'hB});
        check("t2_depth1", {59'd0, irq_depth}, 64'd1);
        do_op(1, OP_POP_CALL, 0, 0, 0);
        check("t2_pop2", {last_link, last_status}, {32'h200, 32'h0});
        do_op(1, OP_POP_IRQ, 0, 0, 0);
        check("t2_pop3", {last_link, last_status}, {32'h100, 32'hA});
        check("t2_depth0", {59'd0, irq_depth}, 64'd0);

`ifdef IRQ_STACK_CHECK_EN
        // Fill and overflow.
        for (int i = 0; i < DEPTH; i++) do_op(1, OP_PUSH_CALL, 32'h1000 + i, 0, 0);
        check("t3_full", {63'd0, full}, 64'd1);
        check("t3_level32", {58'd0, level}, 64'd32);
        do_op(1, OP_PUSH_CALL, 32'hDEAD, 0, 0);
        check("t3_ovf_err", {63'd0, last_err}, 64'd1);
        check("t3_ovf_flag", {63'd0, err_overflow}, 64'd1);
        check("t3_ovf_level", {58'd0, level}, 64'd32);
        do_op(1, OP_POP_CALL, 0, 0, 0);
        check("t3_pop_top", {32'd0, last_link}, 64'h101F);
        do_op(1, OP_PUSH_IRQ, 32'hBEEF, 32'h1, 0);
        check("t3_irq_ovf_err", {63'd0, last_err}, 64'd1);
        check("t3_irq_ovf_level", {58'd0, level}, 64'd31);
        do_op(0, OP_PUSH_CALL, 0, 0, 1);
        for (int i = 0; i < DEPTH - 1; i++) do_op(1, OP_POP_CALL, 0, 0, 0);

        // Underflow and sticky clear.
        do_op(1, OP_POP_CALL, 0, 0, 0);
        check("t4_unf_flag", {63'd0, err_underflow}, 64'd1);
        do_op(0, OP_PUSH_CALL, 0, 0, 1);
        check("t4_unf_cleared", {63'd0, err_underflow}, 64'd0);
        do_op(1, OP_POP_IRQ, 0, 0, 1);
        check("t4_unf_clr_same_cycle", {63'd0, err_underflow}, 64'd1);
        do_op(0, OP_PUSH_CALL, 0, 0, 1);

        // Frame-type mismatch.
        do_op(1, OP_PUSH_CALL, 32'h40, 0, 0);
        do_op(1, OP_POP_IRQ, 0, 0, 0);
        check("t5_mis_flag", {63'd0, err_mismatch}, 64'd1);
        check("t5_mis_level", {58'd0, level}, 64'd1);
        do_op(1, OP_POP_CALL, 0, 0, 0);
        check("t5_link", {32'd0, last_link}, 64'h40);
`else
        // Legacy wrap: 33 pushes leave level at 1, never an error response.
        for (int i = 0; i < DEPTH + 1; i++) do_op(1, OP_PUSH_CALL, 32'h2000 + i, 0, 0);
        check("t6_wrap_level", {58'd0, level}, 64'd1);
        check("t6_no_full", {63'd0, full}, 64'd0);
        do_op(1, OP_POP_CALL, 0, 0, 0);
        check("t6_wrap_pop", {32'd0, last_link}, 64'h2020);
        check("t6_no_err", {63'd0, last_err}, 64'd0);
`endif

        // Reset mid-burst with a response pending.
        do_op(1, OP_PUSH_CALL, 32'h77, 0, 0);
        do_op(1, OP_PUSH_IRQ, 32'h88, 32'h99, 0);
        op_valid = 1'b1;
        op       = OP_POP_IRQ;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
        rst_n    = 1'b0;
        #1;
        model_reset();
        check_reset_values();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) begin
            @(posedge clk);
            #1;
            check_outputs();
        end
        check_reset_values();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
